// File: rtl/vx_fetch_pkg.sv
// Shared types and defaults for the fetch stage: tag-table entry, fetch output
// word layout and the warp-id width helper.
package vx_fetch_pkg;

    function automatic int nw_width(input int num_warps);
        return (num_warps > 1) ? $clog2(num_warps) : 1;
    endfunction

    localparam int DEF_NUM_WARPS       = 4;
    localparam int DEF_NUM_THREADS     = 4;
    localparam int DEF_XLEN            = 32;
    localparam int DEF_UUID_WIDTH      = 1;
    localparam int DEF_MAX_OUTSTANDING = 4;
    localparam int DEF_NW_WIDTH        = nw_width(DEF_NUM_WARPS);

    typedef struct packed {
        logic [DEF_UUID_WIDTH-1:0]  uuid;
        logic [DEF_NUM_THREADS-1:0] tmask;
        logic [DEF_XLEN-1:0]        pc;
    } tag_entry_t;

    // Field order is the wire order toward decode, MSB first.
    typedef struct packed {
        logic [DEF_UUID_WIDTH-1:0]  uuid;
        logic [DEF_NW_WIDTH-1:0]    wid;
        logic [DEF_NUM_THREADS-1:0] tmask;
        logic [DEF_XLEN-1:0]        pc;
        logic [31:0]                instr;
    } fetch_data_t;

    localparam int DEF_FETCH_DATAW = $bits(fetch_data_t);

endpackage

// File: rtl/vx_fetch_if.sv
// Schedule, icache request/response and fetch-output handshakes of the fetch stage.
// The master modport is the fetch stage itself; slave is its environment.
interface vx_fetch_if
    import vx_fetch_pkg::*;
#(
    parameter int NW_WIDTH    = DEF_NW_WIDTH,
    parameter int NUM_THREADS = DEF_NUM_THREADS,
    parameter int XLEN        = DEF_XLEN,
    parameter int UUID_WIDTH  = DEF_UUID_WIDTH
);
    localparam int FETCH_DATAW = UUID_WIDTH + NW_WIDTH + NUM_THREADS + XLEN + 32;

    logic                   sched_valid;
    logic [NW_WIDTH-1:0]    sched_wid;
    logic [NUM_THREADS-1:0] sched_tmask;
    logic [XLEN-1:0]        sched_pc;
    logic [UUID_WIDTH-1:0]  sched_uuid;
    logic                   sched_ready;

    logic                   icache_req_valid;
    logic [XLEN-3:0]        icache_req_addr;
    logic [NW_WIDTH-1:0]    icache_req_tag;
    logic                   icache_req_ready;

    logic                   icache_rsp_valid;
    logic [31:0]            icache_rsp_data;
    logic [NW_WIDTH-1:0]    icache_rsp_tag;
    logic                   icache_rsp_ready;

    logic                   fetch_valid;
    logic [FETCH_DATAW-1:0] fetch_data;
    logic                   fetch_ready;

    modport master (
        input  sched_valid, sched_wid, sched_tmask, sched_pc, sched_uuid,
        output sched_ready,
        output icache_req_valid, icache_req_addr, icache_req_tag,
        input  icache_req_ready,
        input  icache_rsp_valid, icache_rsp_data, icache_rsp_tag,
        output icache_rsp_ready,
        output fetch_valid, fetch_data,
        input  fetch_ready
    );

    modport slave (
        output sched_valid, sched_wid, sched_tmask, sched_pc, sched_uuid,
        input  sched_ready,
        input  icache_req_valid, icache_req_addr, icache_req_tag,
        output icache_req_ready,
        output icache_rsp_valid, icache_rsp_data, icache_rsp_tag,
        input  icache_rsp_ready,
        input  fetch_valid, fetch_data,
        output fetch_ready
    );

endinterface

// File: rtl/vx_fetch_elastic_buf.sv
// Two-entry valid/ready buffer: full throughput at one entry, absorbs one extra
// word when the consumer stalls. Head data never moves while it is presented.
module vx_fetch_elastic_buf #(
    parameter int DATAW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [DATAW-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [DATAW-1:0] out_data,
    input  logic             out_ready
);
    logic [DATAW-1:0] slot [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = slot[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) slot[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/vx_fetch_stage.sv
// Fetch stage: issues one icache read per scheduled warp, remembers the request
// in a per-warp tag table and joins returning words into the fetch output buffer.
module vx_fetch_stage
    import vx_fetch_pkg::*;
#(
    parameter int NUM_WARPS       = DEF_NUM_WARPS,
    parameter int NUM_THREADS     = DEF_NUM_THREADS,
    parameter int XLEN            = DEF_XLEN,
    parameter int UUID_WIDTH      = DEF_UUID_WIDTH,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic       clk,
    input  logic       reset,
    vx_fetch_if.master fif,
    output logic       busy
);
    localparam int NW_WIDTH    = nw_width(NUM_WARPS);
    localparam int OUT_WIDTH   = $clog2(MAX_OUTSTANDING + 1);
    localparam int FETCH_DATAW = UUID_WIDTH + NW_WIDTH + NUM_THREADS + XLEN + 32;

    logic [NUM_WARPS-1:0]   pending;
    logic [OUT_WIDTH-1:0]   outstanding;
    tag_entry_t             tag_table [NUM_WARPS];

    logic                   sched_open;
    logic                   fire;
    logic                   rsp_accept;
    logic                   rsp_hit;
    fetch_data_t            rsp_word;
    logic                   buf_in_ready;
    logic                   buf_out_valid;
    logic [FETCH_DATAW-1:0] buf_out_data;
    logic [4:0]             settle_cnt;

    // Everything toward the outside is forced low while reset is held.
    assign sched_open = reset & ~pending[fif.sched_wid]
                      & (outstanding < OUT_WIDTH'(MAX_OUTSTANDING));

    assign fif.icache_req_valid = fif.sched_valid & sched_open;
    assign fif.sched_ready      = sched_open & fif.icache_req_ready;
    assign fif.icache_req_addr  = reset ? fif.sched_pc[XLEN-1:2] : '0;
    assign fif.icache_req_tag   = reset ? fif.sched_wid : '0;
    assign fire                 = fif.sched_valid & fif.sched_ready;

    // Stale tags are still accepted so the icache never stalls on them.
    assign fif.icache_rsp_ready = reset & buf_in_ready;
    assign rsp_accept           = fif.icache_rsp_valid & fif.icache_rsp_ready;
    assign rsp_hit              = rsp_accept & pending[fif.icache_rsp_tag];

    always_comb begin
        rsp_word       = '0;
        rsp_word.uuid  = tag_table[fif.icache_rsp_tag].uuid;
        rsp_word.wid   = fif.icache_rsp_tag;
        rsp_word.tmask = tag_table[fif.icache_rsp_tag].tmask;
        rsp_word.pc    = tag_table[fif.icache_rsp_tag].pc;
        rsp_word.instr = fif.icache_rsp_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending     <= '0;
            outstanding <= '0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (fire && (fif.sched_wid == NW_WIDTH'(w)))
                    pending[w] <= 1'b1;
                else if (rsp_hit && (fif.icache_rsp_tag == NW_WIDTH'(w)))
                    pending[w] <= 1'b0;
            end
            if (fire && !rsp_hit)
                outstanding <= outstanding + OUT_WIDTH'(1);
            else if (!fire && rsp_hit)
                outstanding <= outstanding - OUT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            tag_table[fif.sched_wid].uuid  <= fif.sched_uuid;
            tag_table[fif.sched_wid].tmask <= fif.sched_tmask;
            tag_table[fif.sched_wid].pc    <= fif.sched_pc;
        end
    end

    vx_fetch_elastic_buf #(
        .DATAW (FETCH_DATAW)
    ) u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rsp_hit),
        .in_data   (rsp_word),
        .in_ready  (buf_in_ready),
        .out_valid (buf_out_valid),
        .out_data  (buf_out_data),
        .out_ready (fif.fetch_ready)
    );

    assign fif.fetch_valid = reset & buf_out_valid;
    assign fif.fetch_data  = reset ? buf_out_data : '0;
    assign busy            = reset & ((outstanding != '0) | buf_out_valid);

    // Responses to requests issued before a reset may trickle in for a while;
    // only after this window is a stale tag treated as a protocol error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            settle_cnt <= '0;
        else if (!settle_cnt[4])
            settle_cnt <= settle_cnt + 5'd1;
    end

    stale_rsp_chk: assert property (@(posedge clk) disable iff (!reset)
        !(settle_cnt[4] && rsp_accept && !rsp_hit));

    outstanding_chk: assert property (@(posedge clk) disable iff (!reset)
        outstanding <= OUT_WIDTH'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_vx_fetch_stage.sv
// Directed bench for vx_fetch_stage with a queue-based reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_vx_fetch_stage;
    import vx_fetch_pkg::*;

    localparam int MAX_OUT = 4;
    localparam int FDW     = DEF_FETCH_DATAW;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   total = 0;
    int   bad   = 0;

    vx_fetch_if fif ();

    vx_fetch_stage #(
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .fif   (fif),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which warps wait on the icache, what they asked for, and
    // the words sitting in the output buffer (front = presented to decode).
    bit             m_pend  [4];
    logic           m_uuid  [4];
    logic [3:0]     m_tmask [4];
    logic [31:0]    m_pc    [4];
    logic [FDW-1:0] m_q [$];

    function automatic int m_count();
        int c = 0;
        for (int w = 0; w < 4; w++) if (m_pend[w]) c++;
        return c;
    endfunction

    function automatic bit m_ok();
        return rst_n && !m_pend[fif.sched_wid] && (m_count() < MAX_OUT);
    endfunction

    function automatic void m_clear();
        for (int w = 0; w < 4; w++) m_pend[w] = 1'b0;
        m_q.delete();
    endfunction

    initial begin : scoreboard
        logic [FDW-1:0] item;
        logic [3:0]     pv;
        logic [1:0]     t;
        bit             fire;
        bit             hit;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_clear();
                check("rst_req_valid", fif.icache_req_valid, 0);
                check("rst_sched_ready", fif.sched_ready, 0);
                check("rst_rsp_ready", fif.icache_rsp_ready, 0);
                check("rst_req_addr", fif.icache_req_addr, 0);
                check("rst_fetch_valid", fif.fetch_valid, 0);
                check("rst_fetch_data", fif.fetch_data, 0);
                check("rst_busy", busy, 0);
            end else begin
                for (int w = 0; w < 4; w++) pv[w] = m_pend[w];
                check("m_req_valid", fif.icache_req_valid, fif.sched_valid && m_ok());
                check("m_sched_ready", fif.sched_ready, m_ok() && fif.icache_req_ready);
                if (fif.sched_valid) begin
                    check("m_req_addr", fif.icache_req_addr, fif.sched_pc >> 2);
                    check("m_req_tag", fif.icache_req_tag, fif.sched_wid);
                end
                check("m_rsp_ready", fif.icache_rsp_ready, m_q.size() < 2);
                check("m_fetch_valid", fif.fetch_valid, m_q.size() != 0);
                if (m_q.size() != 0) check("m_fetch_data", fif.fetch_data, m_q[0]);
                check("m_busy", busy, (m_count() != 0) || (m_q.size() != 0));
                check("m_outstanding", dut.outstanding, m_count());
                check("m_pending", dut.pending, pv);
            end
            @(posedge clk);
            if (!rst_n) begin
                m_clear();
            end else begin
                t    = fif.icache_rsp_tag;
                fire = fif.sched_valid && m_ok() && fif.icache_req_ready;
                hit  = fif.icache_rsp_valid && (m_q.size() < 2) && m_pend[t];
                item = {m_uuid[t], t, m_tmask[t], m_pc[t], fif.icache_rsp_data};
                if ((m_q.size() != 0) && fif.fetch_ready) void'(m_q.pop_front());
                if (hit) begin
                    m_q.push_back(item);
                    m_pend[t] = 1'b0;
                end
                if (fire) begin
                    m_pend[fif.sched_wid]  = 1'b1;
                    m_uuid[fif.sched_wid]  = fif.sched_uuid;
                    m_tmask[fif.sched_wid] = fif.sched_tmask;
                    m_pc[fif.sched_wid]    = fif.sched_pc;
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int wid, input logic [31:0] pc, input logic [3:0] tm, input logic u);
        fif.sched_valid = 1'b1;
        fif.sched_wid   = 2'(wid);
        fif.sched_pc    = pc;
        fif.sched_tmask = tm;
        fif.sched_uuid  = u;
    endtask

    task automatic rsp(input int tag, input logic [31:0] data);
        fif.icache_rsp_valid = 1'b1;
        fif.icache_rsp_tag   = 2'(tag);
        fif.icache_rsp_data  = data;
    endtask

    initial begin : stimulus
        fetch_data_t head;
        int          got [$];
        bit          acc;

        rst_n                = 1'b0;
        fif.icache_req_ready = 1'b1;
        fif.icache_rsp_valid = 1'b0;
        fif.icache_rsp_tag   = '0;
        fif.icache_rsp_data  = '0;
        fif.fetch_ready      = 1'b1;
        req(3, 32'h0000_0040, 4'b1111, 1'b1);

        // Reset holds every output low even with a request pending on the inputs.
        repeat (3) tick();
        @(negedge clk);
        check("reset_req_valid", fif.icache_req_valid, 0);
        check("reset_sched_ready", fif.sched_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_fetch_valid", fif.fetch_valid, 0);
        tick();
        fif.sched_valid = 1'b0;
        rst_n = 1'b1;

        // Single fetch
        tick();
        req(2, 32'h8000_0010, 4'b1011, 1'b1);
        @(negedge clk);
        check("t1_req_valid", fif.icache_req_valid, 1);
        check("t1_req_addr", fif.icache_req_addr, 30'h2000_0004);
        check("t1_req_tag", fif.icache_req_tag, 2);
        tick();
        fif.sched_valid = 1'b0;
        tick();
        rsp(2, 32'h00A0_0093);
        @(negedge clk);
        check("t1_no_early_valid", fif.fetch_valid, 0);
        tick();
        fif.icache_rsp_valid = 1'b0;
        @(negedge clk);
        check("t1_fetch_valid", fif.fetch_valid, 1);
        check("t1_fetch_data", fif.fetch_data, {1'b1, 2'd2, 4'b1011, 32'h8000_0010, 32'h00A0_0093});
        tick();
        @(negedge clk);
        check("t1_drained_busy", busy, 0);

        // Per-warp blocking
        tick();
        req(1, 32'h0000_0100, 4'b0001, 1'b0);
        @(negedge clk);
        check("t2_first_ready", fif.sched_ready, 1);
        tick();
        req(1, 32'h0000_0104, 4'b0010, 1'b1);
        @(negedge clk);
        check("t2_blocked", fif.sched_ready, 0);
        check("t2_blocked_req_valid", fif.icache_req_valid, 0);
        tick();
        rsp(1, 32'h0000_0011);
        @(negedge clk);
        check("t2_blocked_same_cycle", fif.sched_ready, 0);
        tick();
        fif.icache_rsp_valid = 1'b0;
        @(negedge clk);
        check("t2_unblocked", fif.sched_ready, 1);
        tick();
        fif.sched_valid = 1'b0;
        rsp(1, 32'h0000_0012);
        tick();
        fif.icache_rsp_valid = 1'b0;
        tick();

        // Outstanding limit
        for (int w = 0; w < 4; w++) begin
            req(w, 32'h0000_0200 + w * 16, 4'(w + 1), 1'(w));
            tick();
        end
        fif.sched_valid = 1'b0;
        @(negedge clk);
        check("t3_outstanding_full", dut.outstanding, 4);
        check("t3_busy", busy, 1);
        req(0, 32'h0000_0300, 4'b1111, 1'b0);
        @(negedge clk);
        check("t3_limit_block", fif.sched_ready, 0);
        check("t3_limit_req_valid", fif.icache_req_valid, 0);
        tick();
        rsp(0, 32'h0000_00C0);
        @(negedge clk);
        check("t3_same_cycle_block", fif.sched_ready, 0);
        tick();
        fif.icache_rsp_valid = 1'b0;
        @(negedge clk);
        check("t3_reissue_ready", fif.sched_ready, 1);
        check("t3_w1_still_pending", dut.pending[1], 1);
        tick();
        fif.sched_valid = 1'b0;
        @(negedge clk);
        check("t3_outstanding_refill", dut.outstanding, 4);
        for (int k = 0; k < 4; k++) begin
            rsp((k + 1) % 4, 32'h0000_00C1 + k);
            tick();
        end
        fif.icache_rsp_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("t3_idle", busy, 0);

        // Backpressure
        tick();
        fif.fetch_ready = 1'b0;
        for (int w = 0; w < 3; w++) begin
            req(w, 32'h0000_0400 + w * 4, 4'b0101, 1'b0);
            tick();
        end
        fif.sched_valid = 1'b0;
        for (int w = 0; w < 2; w++) begin
            rsp(w, 32'h0000_00B0 + w);
            tick();
        end
        rsp(2, 32'h0000_00B2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            head = fif.fetch_data;
            check("t4_third_blocked", fif.icache_rsp_ready, 0);
            check("t4_head_wid", head.wid, 0);
            check("t4_head_instr", head.instr, 32'h0000_00B0);
        end
        tick();
        fif.fetch_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            acc = fif.icache_rsp_valid && fif.icache_rsp_ready;
            if (fif.fetch_valid && fif.fetch_ready) begin
                head = fif.fetch_data;
                got.push_back(int'(head.wid));
            end
            tick();
            if (acc) fif.icache_rsp_valid = 1'b0;
        end
        check("t4_out_count", got.size(), 3);
        for (int i = 0; i < got.size(); i++) check("t4_out_order", got[i], i);

        // Reset mid-operation, then a stale response
        for (int w = 1; w < 4; w++) begin
            req(w, 32'h0000_0500 + w * 4, 4'b0011, 1'b1);
            tick();
        end
        fif.sched_valid = 1'b0;
        @(negedge clk);
        check("t5_outstanding3", dut.outstanding, 3);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_outstanding", dut.outstanding, 0);
        check("t5_rst_busy", busy, 0);
        tick();
        tick();
        rst_n = 1'b1;
        rsp(3, 32'h0000_DEAD);
        @(negedge clk);
        check("t5_stale_ready", fif.icache_rsp_ready, 1);
        tick();
        fif.icache_rsp_valid = 1'b0;
        @(negedge clk);
        check("t5_stale_no_valid", fif.fetch_valid, 0);
        check("t5_stale_outstanding", dut.outstanding, 0);
        check("t5_stale_busy", busy, 0);
        tick();

        // Fire and response accept in the same cycle
        req(1, 32'h0000_0600, 4'b1000, 1'b0);
        tick();
        req(0, 32'h0000_0700, 4'b0100, 1'b1);
        rsp(1, 32'h0000_0066);
        @(negedge clk);
        check("t6_sched_ready", fif.sched_ready, 1);
        check("t6_rsp_ready", fif.icache_rsp_ready, 1);
        check("t6_outstanding_before", dut.outstanding, 1);
        tick();
        fif.sched_valid      = 1'b0;
        fif.icache_rsp_valid = 1'b0;
        @(negedge clk);
        check("t6_outstanding_same", dut.outstanding, 1);
        check("t6_pending0", dut.pending[0], 1);
        check("t6_pending1", dut.pending[1], 0);
        check("t6_fetch_data", fif.fetch_data, {1'b0, 2'd1, 4'b1000, 32'h0000_0600, 32'h0000_0066});
        tick();
        rsp(0, 32'h0000_0077);
        tick();
        fif.icache_rsp_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("t6_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
